// File: rtl/sram_array.sv
// sram_array: parametrised synchronous SRAM with a registered read port,
// a post-reset hardware clear sequence (busy) and dropped-request reporting.
// Access convention: sel=1 requests an access, RW=1 read, RW=0 write.
// Optional feature macro: SRAM_WRITE_THROUGH_EN -- when defined, a write also
// drives dout<=din and pulses dout_valid.
module sram_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              RW,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              req_drop
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] IDLE  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic clear_last;
   logic do_read;
   logic do_write;

   // The clear pointer reaches its terminal word when every bit is set.
   assign clear_last = &ptr;
   assign do_read    = (state == IDLE) && sel && RW;
   assign do_write   = (state == IDLE) && sel && !RW;

   // busy is the registered CLEAR state itself, so it falls on the terminal edge.
   assign busy = (state == CLEAR);

   // Sequencer: walk the clear pointer once after reset, then park in IDLE.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else if (state == CLEAR) begin
         ptr   <= clear_last ? '0 : ptr + ADDR_W'(1);
         state <= clear_last ? IDLE : CLEAR;
      end
   end

   // Output register: read data, its valid pulse, and the drop pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         req_drop   <= 1'b0;
      end else begin
         req_drop <= (state == CLEAR) && sel;
`ifdef SRAM_WRITE_THROUGH_EN
         dout_valid <= do_read || do_write;
         if (do_read)
            dout <= mem[addr];
         else if (do_write)
            dout <= din;
`else
         dout_valid <= do_read;
         if (do_read)
            dout <= mem[addr];
`endif
      end
   end

   // Storage: zeroed word by word during CLEAR, written by accepted writes.
   // NOTE: the array has no reset term on purpose; an async reset on every
   // word would prevent RAM inference, so the CLEAR walk zeroes it instead.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[ptr] <= '0;
      else if (do_write)
         mem[addr] <= din;
   end

endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array: directed test-plan scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the SRAM (word array + clear
// countdown). Honours SRAM_WRITE_THROUGH_EN the same way the design does.
module tb_sram_array;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sel = 1'b0;
   logic              RW  = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] din  = '0;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              busy;
   logic              req_drop;

   int n_checks = 0;
   int n_pass   = 0;

   sram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .RW         (RW),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .req_drop   (req_drop)
   );

   always #5 clk = ~clk;

`ifdef SRAM_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // After reset the array is all zeros as far as any observer can tell;
   // the model simply counts down the DEPTH busy edges.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_left;
   logic [DATA_W-1:0] m_dout;
   bit                m_valid;
   bit                m_drop;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left  = DEPTH;
         m_dout  = '0;
         m_valid = 1'b0;
         m_drop  = 1'b0;
         foreach (m_mem[i]) m_mem[i] = '0;
      end else if (m_left > 0) begin
         m_left  = m_left - 1;
         m_drop  = sel;
         m_valid = 1'b0;
      end else begin
         m_drop  = 1'b0;
         m_valid = 1'b0;
         if (sel && RW) begin
            m_dout  = m_mem[addr];
            m_valid = 1'b1;
         end else if (sel) begin
            m_mem[addr] = din;
            if (WT) begin
               m_dout  = din;
               m_valid = 1'b1;
            end
         end
      end
   end

   // Compare process: outputs are registered, so check mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", 32'(busy), 32'(m_left > 0));
         check("dout_valid", 32'(dout_valid), 32'(m_valid));
         check("req_drop", 32'(req_drop), 32'(m_drop));
         check("dout", 32'(dout), 32'(m_dout));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic op(input logic s, input logic rw, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
      @(negedge clk);
      #1;
      sel  = s;
      RW   = rw;
      addr = a;
      din  = d;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, '0, '0);
   endtask

   // Issue a read and check the registered result right after its sample edge.
   task automatic read_expect(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                              input string name);
      op(1'b1, 1'b1, a, '0);
      @(posedge clk);
      #1;
      check({name, "_dout"}, 32'(dout), 32'(exp));
      check({name, "_valid"}, 32'(dout_valid), 32'd1);
   endtask

   // Count rising edges from now until busy falls (bounded).
   task automatic count_clear(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 200);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      #1;
      sel = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_drop", 32'(req_drop), 32'h0);
      #1;
      rst = 1'b0;

      // Clear takes exactly DEPTH edges after reset release.
      count_clear(n);
      check("clear_edges", 32'(n), 32'd16);

      // Fresh array reads back zero everywhere.
      for (int a = 0; a < DEPTH; a++)
         read_expect(ADDR_W'(a), 8'h00, "zero_rd");
      idle();

      // Write then immediate read of the same address.
      op(1'b1, 1'b0, 4'h3, 8'hA5);
      read_expect(4'h3, 8'hA5, "wr_rd");
      idle();
      @(posedge clk);
      #1;
      check("valid_one_cycle", 32'(dout_valid), 32'h0);

      // Back-to-back reads keep dout_valid high.
      op(1'b1, 1'b0, 4'h1, 8'h11);
      op(1'b1, 1'b0, 4'h2, 8'h22);
      op(1'b1, 1'b0, 4'h3, 8'h33);
      read_expect(4'h1, 8'h11, "b2b1");
      read_expect(4'h2, 8'h22, "b2b2");
      read_expect(4'h3, 8'h33, "b2b3");
      idle();

      // Request during busy is dropped and leaves memory untouched.
      pulse_rst();
      op(1'b1, 1'b0, 4'h0, 8'hFF);
      @(posedge clk);
      #1;
      check("drop_pulse", 32'(req_drop), 32'h1);
      check("drop_no_valid", 32'(dout_valid), 32'h0);
      idle();
      count_clear(n);
      read_expect(4'h0, 8'h00, "drop_rd0");
      idle();

      // Reset in the middle of CLEAR restarts the full sequence.
      op(1'b1, 1'b0, 4'h3, 8'hA5);
      idle();
      pulse_rst();
      repeat (9) @(posedge clk);
      pulse_rst();
      count_clear(n);
      check("reclear_edges", 32'(n), 32'd16);
      read_expect(4'h3, 8'h00, "reclear_rd3");
      idle();

      // Write to 0x7: write-through drives dout, otherwise dout holds 0x00.
      op(1'b1, 1'b0, 4'h7, 8'h5A);
      @(posedge clk);
      #1;
      check("wt_dout", 32'(dout), WT ? 32'h5A : 32'h00);
      check("wt_valid", 32'(dout_valid), WT ? 32'h1 : 32'h0);
      idle();

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_rst();
         end else begin
            op(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
         end
      end
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
